// File: rtl/garbage_queue_ctrl.sv
// garbage_queue_ctrl: queues incoming garbage batches, cancels them against
// outgoing attacks, offers leftover attack to the LAN and pushes pending
// garbage into the playfield after a non-clearing lock.
// Optional feature macro: GARBAGE_CANCEL_EN (attack cancels queued garbage
// before anything is sent; without it the attack is sent untouched).
module garbage_queue_ctrl #(
  parameter int QUEUE_DEPTH = 8,
  parameter int MAX_PENDING = 20
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       recv_valid,
  input  logic [4:0] recv_lines,
  output logic       recv_ready,
  input  logic       lock_valid,
  input  logic [2:0] lines_cleared,
  input  logic [4:0] attack_lines,
  output logic       send_valid,
  output logic [4:0] send_lines,
  input  logic       send_ready,
  output logic       insert_valid,
  output logic [4:0] insert_lines,
  output logic [3:0] insert_hole_col,
  input  logic       insert_done,
  output logic [4:0] pending_total,
  output logic       busy
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(QUEUE_DEPTH);
  localparam logic [4:0]    MAXP_C    = 5'(MAX_PENDING);
  localparam logic [3:0]    LFSR_SEED = 4'b1001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CANCEL = 2'd1,
    SEND   = 2'd2,
    INSERT = 2'd3
  } state_t;

  // Fold the 1..15 LFSR range onto playfield columns 0..9.
  function automatic logic [3:0] hole_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  state_t          state_r, state_s;
  logic [PW-1:0]   head_r, head_s, tail_r, tail_s;
  logic [CW-1:0]   count_r, count_s;
  logic [4:0]      pending_r, pending_s;
  logic [4:0]      attack_rem_r, attack_rem_s;
  logic [3:0]      lfsr_r;
  logic            send_valid_r, send_valid_s;
  logic [4:0]      send_lines_r, send_lines_s;
  logic            insert_valid_r, insert_valid_s;
  logic [4:0]      insert_lines_r, insert_lines_s;
  logic [3:0]      hole_r, hole_s;
  logic            busy_r;
  logic [4:0]      mem_r [QUEUE_DEPTH];

  logic            we_s;
  logic [PW-1:0]   waddr_s;
  logic [4:0]      wdata_s;
  logic            full_s, ready_s, accept_s;
  logic [4:0]      room_s, store_s, head_val_s;

  assign full_s     = (count_r == DEPTH_C);
  assign ready_s    = (state_r == IDLE) && !full_s && !lock_valid;
  assign accept_s   = recv_valid && ready_s;
  assign room_s     = MAXP_C - pending_r;
  assign store_s    = (recv_lines < room_s) ? recv_lines : room_s;
  assign head_val_s = mem_r[head_r];

`ifndef GARBAGE_CANCEL_EN
  // Entries are never read back without cancelling; keep the head read observable.
  logic unused_head_s;
  assign unused_head_s = ^head_val_s;
`endif

  // recv_ready is forced low while reset is held so every output reads 0.
  assign recv_ready      = rst_l & ready_s;
  assign send_valid      = send_valid_r;
  assign send_lines      = send_lines_r;
  assign insert_valid    = insert_valid_r;
  assign insert_lines    = insert_lines_r;
  assign insert_hole_col = hole_r;
  assign pending_total   = pending_r;
  assign busy            = busy_r;

  // Next-state, queue bookkeeping and output-register next values.
  always_comb begin
    state_s        = state_r;
    head_s         = head_r;
    tail_s         = tail_r;
    count_s        = count_r;
    pending_s      = pending_r;
    attack_rem_s   = attack_rem_r;
    send_valid_s   = send_valid_r;
    send_lines_s   = send_lines_r;
    insert_valid_s = insert_valid_r;
    insert_lines_s = insert_lines_r;
    hole_s         = hole_r;
    we_s           = 1'b0;
    waddr_s        = tail_r;
    wdata_s        = store_s;
    case (state_r)
      IDLE: begin
        if (lock_valid) begin
          if ((lines_cleared == 3'd0) && (pending_r != 5'd0)) begin
            state_s        = INSERT;
            insert_valid_s = 1'b1;
            insert_lines_s = pending_r;
            hole_s         = hole_of(lfsr_r);
            head_s         = tail_r;
            count_s        = {CW{1'b0}};
            pending_s      = 5'd0;
          end else if ((lines_cleared != 3'd0) && (attack_lines != 5'd0)) begin
`ifdef GARBAGE_CANCEL_EN
            state_s      = CANCEL;
            attack_rem_s = attack_lines;
`else
            state_s      = SEND;
            send_valid_s = 1'b1;
            send_lines_s = attack_lines;
`endif
          end else begin
            state_s = IDLE;
          end
        end else if (accept_s && (store_s != 5'd0)) begin
          we_s      = 1'b1;
          tail_s    = tail_r + PW'(1);
          count_s   = count_r + CW'(1);
          pending_s = pending_r + store_s;
        end else begin
          state_s = IDLE;
        end
      end
      CANCEL: begin
`ifdef GARBAGE_CANCEL_EN
        if (attack_rem_r == 5'd0) begin
          state_s = IDLE;
        end else if (count_r == {CW{1'b0}}) begin
          state_s      = SEND;
          send_valid_s = 1'b1;
          send_lines_s = attack_rem_r;
          attack_rem_s = 5'd0;
        end else if (attack_rem_r >= head_val_s) begin
          attack_rem_s = attack_rem_r - head_val_s;
          head_s       = head_r + PW'(1);
          count_s      = count_r - CW'(1);
          pending_s    = pending_r - head_val_s;
        end else begin
          we_s         = 1'b1;
          waddr_s      = head_r;
          wdata_s      = head_val_s - attack_rem_r;
          pending_s    = pending_r - attack_rem_r;
          attack_rem_s = 5'd0;
        end
`else
        state_s = IDLE;
`endif
      end
      SEND: begin
        if (send_ready) begin
          state_s      = IDLE;
          send_valid_s = 1'b0;
          send_lines_s = 5'd0;
        end else begin
          state_s = SEND;
        end
      end
      INSERT: begin
        if (insert_done) begin
          state_s        = IDLE;
          insert_valid_s = 1'b0;
          insert_lines_s = 5'd0;
          hole_s         = 4'd0;
        end else begin
          state_s = INSERT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pointer, counter and output registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r        <= IDLE;
      head_r         <= {PW{1'b0}};
      tail_r         <= {PW{1'b0}};
      count_r        <= {CW{1'b0}};
      pending_r      <= 5'd0;
      attack_rem_r   <= 5'd0;
      send_valid_r   <= 1'b0;
      send_lines_r   <= 5'd0;
      insert_valid_r <= 1'b0;
      insert_lines_r <= 5'd0;
      hole_r         <= 4'd0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      head_r         <= head_s;
      tail_r         <= tail_s;
      count_r        <= count_s;
      pending_r      <= pending_s;
      attack_rem_r   <= attack_rem_s;
      send_valid_r   <= send_valid_s;
      send_lines_r   <= send_lines_s;
      insert_valid_r <= insert_valid_s;
      insert_lines_r <= insert_lines_s;
      hole_r         <= hole_s;
      busy_r         <= (state_s != IDLE);
    end
  end

  // Free-running hole generator, x^4+x^3+1.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[2:0], lfsr_r[3] ^ lfsr_r[2]};
    end
  end

  // Batch storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

endmodule

// File: tb/tb_garbage_queue_ctrl.sv
// Scoreboard bench for garbage_queue_ctrl with a queue-based reference model.
module tb_garbage_queue_ctrl;

  localparam int QD = 8;
  localparam int MP = 20;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       recv_valid = 1'b0;
  logic [4:0] recv_lines = 5'd0;
  logic       recv_ready;
  logic       lock_valid = 1'b0;
  logic [2:0] lines_cleared = 3'd0;
  logic [4:0] attack_lines = 5'd0;
  logic       send_valid;
  logic [4:0] send_lines;
  logic       send_ready = 1'b0;
  logic       insert_valid;
  logic [4:0] insert_lines;
  logic [3:0] insert_hole_col;
  logic       insert_done = 1'b0;
  logic [4:0] pending_total;
  logic       busy;

  garbage_queue_ctrl #(.QUEUE_DEPTH(QD), .MAX_PENDING(MP)) dut (
    .clk(clk), .rst_l(rst_l),
    .recv_valid(recv_valid), .recv_lines(recv_lines), .recv_ready(recv_ready),
    .lock_valid(lock_valid), .lines_cleared(lines_cleared), .attack_lines(attack_lines),
    .send_valid(send_valid), .send_lines(send_lines), .send_ready(send_ready),
    .insert_valid(insert_valid), .insert_lines(insert_lines),
    .insert_hole_col(insert_hole_col), .insert_done(insert_done),
    .pending_total(pending_total), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mq[$];
  int exp_send[$];
  int exp_ins_lines[$];
  int exp_ins_hole[$];
  logic [3:0] m_lfsr;
  bit hold_send = 1'b0;
  bit prev_ins  = 1'b0;

  task automatic chk(string nm, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int msum();
    int s = 0;
    foreach (mq[i]) s += mq[i];
    return s;
  endfunction

  // Reference hole source: same polynomial, stepped once per clock out of reset.
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) m_lfsr <= 4'b1001;
    else        m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end

  function automatic void model_recv(int n);
    int room = MP - msum();
    int st = (n < room) ? n : room;
    if (st > 0) mq.push_back(st);
  endfunction

  function automatic void model_lock(int clr, int atk);
    if (clr == 0 && msum() > 0) begin
      exp_ins_lines.push_back(msum());
      exp_ins_hole.push_back(int'(m_lfsr) % 10);
      mq.delete();
    end else if (clr > 0 && atk > 0) begin
`ifdef GARBAGE_CANCEL_EN
      int rem = atk;
      while (rem > 0 && mq.size() > 0) begin
        if (rem >= mq[0]) begin
          rem -= mq[0];
          void'(mq.pop_front());
        end else begin
          mq[0] -= rem;
          rem = 0;
        end
      end
      if (rem > 0) exp_send.push_back(rem);
`else
      exp_send.push_back(atk);
`endif
    end
  endfunction

  // LAN/playfield responder: random handshakes, also outside their states.
  initial begin
    forever begin
      @(negedge clk);
      send_ready  = hold_send ? 1'b0 : ($urandom_range(0, 2) == 0);
      insert_done = ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: compares every offer and every new insert request against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_l) begin
        prev_ins = 1'b0;
      end else begin
        if (send_valid) begin
          if (exp_send.size() == 0) begin
            chk("unexpected_send_valid", send_valid, 0);
          end else begin
            chk("send_lines", send_lines, exp_send[0]);
            if (send_ready) void'(exp_send.pop_front());
          end
        end
        if (insert_valid && !prev_ins) begin
          if (exp_ins_lines.size() == 0) begin
            chk("unexpected_insert_valid", insert_valid, 0);
          end else begin
            chk("insert_lines", insert_lines, exp_ins_lines.pop_front());
            chk("insert_hole_col", insert_hole_col, exp_ins_hole.pop_front());
          end
        end
        prev_ins = insert_valid;
      end
    end
  end

  task automatic drive_recv(int n);
    int exp_rdy;
    @(negedge clk);
    recv_valid = 1'b1;
    recv_lines = 5'(n);
    #1;
    exp_rdy = (mq.size() < QD) ? 1 : 0;
    chk("recv_ready", recv_ready, exp_rdy);
    @(posedge clk);
    if (exp_rdy == 1) model_recv(n);
    #1;
    recv_valid = 1'b0;
    chk("pending_after_recv", pending_total, msum());
  endtask

  task automatic issue_lock(int clr, int atk, bit with_recv, int rl);
    @(negedge clk);
    lock_valid    = 1'b1;
    lines_cleared = 3'(clr);
    attack_lines  = 5'(atk);
    if (with_recv) begin
      recv_valid = 1'b1;
      recv_lines = 5'(rl);
    end
    #1;
    chk("recv_ready_low_on_lock", recv_ready, 0);
    model_lock(clr, atk);
    @(posedge clk);
    #1;
    lock_valid = 1'b0;
    recv_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("idle_within_bound", busy, 0);
    chk("pending_after_op", pending_total, msum());
  endtask

  task automatic lock_op(int clr, int atk);
    issue_lock(clr, atk, 1'b0, 0);
    wait_idle();
  endtask

  task automatic flush();
    if (msum() > 0) lock_op(0, 0);
  endtask

  task automatic wait_send_valid();
    int i = 0;
    while (!send_valid && i < 50) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("send_valid_seen", send_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #6;
    chk("rst_recv_ready", recv_ready, 0);
    chk("rst_send_valid", send_valid, 0);
    chk("rst_send_lines", send_lines, 0);
    chk("rst_insert_valid", insert_valid, 0);
    chk("rst_insert_lines", insert_lines, 0);
    chk("rst_hole", insert_hole_col, 0);
    chk("rst_pending", pending_total, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;

    // 3, 5, 0 -> two entries totalling 8, then insert of 8
    drive_recv(3); drive_recv(5); drive_recv(0);
    chk("pending_eq_8", pending_total, 8);
    lock_op(0, 0);

    // Attack 4 against queued 3, 5
    drive_recv(3); drive_recv(5);
    lock_op(2, 4);
    flush();

    // Attack 6 against queued 2, offer held for 5 cycles
    drive_recv(2);
    hold_send = 1'b1;
    issue_lock(1, 6, 1'b0, 0);
    wait_send_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("send_valid_held", send_valid, 1);
    end
    hold_send = 1'b0;
    wait_idle();
    flush();

    // Saturation at MAX_PENDING
    drive_recv(18); drive_recv(7);
    chk("pending_saturated", pending_total, 20);
    drive_recv(1);
    chk("pending_stays_20", pending_total, 20);
    flush();

    // Simultaneous receive and lock: lock wins
    drive_recv(3);
    issue_lock(0, 0, 1'b1, 5);
    wait_idle();

    // Fill to full, flush, fill again across the wrapped pointers
    for (int k = 0; k < QD; k++) drive_recv(1);
    drive_recv(1);
    flush();
    for (int k = 0; k < QD; k++) drive_recv(2);
    lock_op(1, 5);
    drive_recv(1);
    flush();

    // Reset while an offer is outstanding
    drive_recv(4);
    hold_send = 1'b1;
    issue_lock(2, 10, 1'b0, 0);
    wait_send_valid();
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("rst_mid_send_valid", send_valid, 0);
    chk("rst_mid_send_lines", send_lines, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pending", pending_total, 0);
    exp_send.delete();
    mq.delete();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    hold_send = 1'b0;
    #1;
    chk("post_rst_send_valid", send_valid, 0);
    chk("post_rst_busy", busy, 0);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) != 0) begin
        drive_recv($urandom_range(0, 20));
      end else begin
        issue_lock($urandom_range(0, 4), $urandom_range(0, 20),
                   1'($urandom_range(0, 1)), $urandom_range(0, 20));
        wait_idle();
      end
    end
    flush();
    repeat (4) @(negedge clk);
    chk("send_scoreboard_drained", exp_send.size(), 0);
    chk("insert_scoreboard_drained", exp_ins_lines.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
